// File: rtl/keccak_padder_if.sv
// Word/block handshake between a message source, the padder and the permutation.
// The master side drives message words and f_ack; the slave side (padder) returns the padded block.
interface keccak_padder_if #(
   parameter int IN_W = 32,
   parameter int RATE = 576
);
   localparam int BNW = $clog2(IN_W / 8);

   logic [IN_W-1:0] in;
   logic            in_ready;
   logic            is_last;
   logic [BNW-1:0]  byte_num;
   logic            buffer_full;
   logic [RATE-1:0] out;
   logic            out_ready;
   logic            f_ack;

   modport master (
      output in, in_ready, is_last, byte_num, f_ack,
      input  buffer_full, out, out_ready
   );

   modport slave (
      input  in, in_ready, is_last, byte_num, f_ack,
      output buffer_full, out, out_ready
   );
endinterface

// File: rtl/keccak_padder_gen.sv
// Keccak input padder: shifts IN_W-bit words into a RATE-bit block, applies DOMAIN..0x80 padding,
// and holds each complete block until the permutation acknowledges it.
module keccak_padder_gen #(
   parameter int          IN_W   = 32,
   parameter int          RATE   = 576,
   parameter logic [7:0]  DOMAIN = 8'h01
) (
   input logic           clk,
   input logic           reset,
   keccak_padder_if.slave bus
);
   localparam int NB  = IN_W / 8;
   localparam int BNW = $clog2(NB);
   localparam int NW  = RATE / IN_W;
   localparam int CW  = $clog2(NW + 1);

   localparam logic [1:0] S_ABSORB = 2'd0;
   localparam logic [1:0] S_PAD    = 2'd1;
   localparam logic [1:0] S_FULL   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RATE-1:0] out_q, out_d;
   logic            final_q, final_d;
   logic            buffer_full_q, buffer_full_d;
   logic            out_ready_q, out_ready_d;

   logic            shift_en;
   logic [IN_W-1:0] word;
   logic [IN_W-1:0] last_word;

   // Final word: keep byte_num message bytes from the MSB side, then DOMAIN, then zeros.
   for (genvar gi = 0; gi < NB; gi++) begin : g_last_byte
      assign last_word[IN_W-1-8*gi -: 8] =
         (BNW'(gi) <  bus.byte_num) ? bus.in[IN_W-1-8*gi -: 8] :
         (BNW'(gi) == bus.byte_num) ? DOMAIN : 8'h00;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      out_d         = out_q;
      final_d       = final_q;
      buffer_full_d = buffer_full_q;
      out_ready_d   = out_ready_q;
      shift_en      = 1'b0;
      word          = '0;

      case (state_q)
         S_ABSORB: begin
            if (bus.in_ready && !buffer_full_q) begin
               shift_en = 1'b1;
               word     = bus.is_last ? last_word : bus.in;
               if (bus.is_last) begin
                  final_d       = 1'b1;
                  state_d       = S_PAD;
                  buffer_full_d = 1'b1;
               end
            end
         end
         S_PAD: begin
            shift_en = 1'b1;
         end
         S_FULL: begin
            if (bus.f_ack) begin
               cnt_d         = '0;
               out_ready_d   = 1'b0;
               state_d       = final_q ? S_DONE : S_ABSORB;
               buffer_full_d = final_q;
            end
         end
         default: ;
      endcase

      // The word that completes the block overrides any PAD decision made above.
      if (shift_en) begin
         out_d = {out_q[RATE-IN_W-1:0], word};
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(NW - 1)) begin
            if (final_d) begin
               out_d[7:0] = out_d[7:0] | 8'h80;
            end
            state_d       = S_FULL;
            buffer_full_d = 1'b1;
            out_ready_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_ABSORB;
         cnt_q         <= '0;
         out_q         <= '0;
         final_q       <= 1'b0;
         buffer_full_q <= 1'b0;
         out_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         out_q         <= out_d;
         final_q       <= final_d;
         buffer_full_q <= buffer_full_d;
         out_ready_q   <= out_ready_d;
      end
   end

   assign bus.out         = out_q;
   assign bus.out_ready   = out_ready_q;
   assign bus.buffer_full = buffer_full_q;
endmodule

// File: tb/tb_keccak_padder_gen.sv
// Randomised bench for keccak_padder_gen: messages are padded by a byte-level model
// (DOMAIN, zero fill, 0x80 on the last byte) and every block is compared against it.
module tb_keccak_padder_gen;
   localparam int AW = 32;
   localparam int AR = 576;
   localparam int ANW = AR / AW;
   localparam int ARB = AR / 8;
   localparam logic [7:0] AD = 8'h01;
   localparam int BW = 64;
   localparam int BR = 1088;
   localparam int BNWD = BR / BW;
   localparam logic [7:0] BD = 8'h06;

   typedef logic [1087:0] cv_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   keccak_padder_if #(.IN_W(AW), .RATE(AR)) a_if ();
   keccak_padder_if #(.IN_W(BW), .RATE(BR)) b_if ();

   keccak_padder_gen #(.IN_W(AW), .RATE(AR), .DOMAIN(AD)) dut_a (
      .clk(clk), .reset(rst_a), .bus(a_if.slave)
   );
   keccak_padder_gen #(.IN_W(BW), .RATE(BR), .DOMAIN(BD)) dut_b (
      .clk(clk), .reset(rst_b), .bus(b_if.slave)
   );

   int total = 0;
   int bad   = 0;
   logic [7:0]    msg_q[$];
   logic [AR-1:0] last_blk;

   task automatic check_val(input string tag, input cv_t got, input cv_t exp);
      int d;
      logic [63:0] gw, ew;
      total++;
      if (got !== exp) begin
         d = 0;
         for (int i = 1087; i >= 0; i--) begin
            if (got[i] !== exp[i]) begin
               d = i;
               break;
            end
         end
         gw = got[(d/64)*64 +: 64];
         ew = exp[(d/64)*64 +: 64];
         bad++;
         $display("FAIL %s: first diff bit %0d, window got=%h exp=%h", tag, d, gw, ew);
      end
   endtask

   // Reference: byte stream = message, DOMAIN, zeros to a block multiple; 0x80 ORed into the final byte.
   function automatic logic [AR-1:0] exp_blk_a(input int blk);
      logic [AR-1:0] v;
      logic [7:0] b;
      int idx;
      v = '0;
      for (int j = 0; j < ARB; j++) begin
         idx = blk * ARB + j;
         if (idx < msg_q.size())       b = msg_q[idx];
         else if (idx == msg_q.size()) b = AD;
         else                          b = 8'h00;
         if (j == ARB - 1 && blk == msg_q.size() / ARB) b = b | 8'h80;
         v[AR-1-8*j -: 8] = b;
      end
      return v;
   endfunction

   task automatic reset_a(input string name);
      @(negedge clk);
      rst_a = 1'b1;
      a_if.in_ready = 1'b0;
      a_if.is_last = 1'b0;
      a_if.f_ack = 1'b0;
      @(negedge clk);
      rst_a = 1'b0;
      check_val({name, "_rst_out"}, cv_t'(a_if.out), cv_t'(0));
      check_val({name, "_rst_bf"},  cv_t'(a_if.buffer_full), cv_t'(0));
      check_val({name, "_rst_rdy"}, cv_t'(a_if.out_ready), cv_t'(0));
   endtask

   task automatic reset_b(input string name);
      @(negedge clk);
      rst_b = 1'b1;
      b_if.in_ready = 1'b0;
      b_if.is_last = 1'b0;
      b_if.f_ack = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      check_val({name, "_rst_out"}, cv_t'(b_if.out), cv_t'(0));
      check_val({name, "_rst_bf"},  cv_t'(b_if.buffer_full), cv_t'(0));
   endtask

   // Hold a junk word (in_ready=1) while the block waits, including on the f_ack cycle.
   task automatic ack_a(input string name, input logic final_blk, input logic [AR-1:0] exp);
      int hold;
      hold = $urandom_range(0, 3);
      a_if.in = "XXXX";
      a_if.is_last = 1'b0;
      a_if.in_ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_val({name, "_hold_rdy"}, cv_t'(a_if.out_ready), cv_t'(1));
         check_val({name, "_hold_bf"},  cv_t'(a_if.buffer_full), cv_t'(1));
         check_val({name, "_hold_out"}, cv_t'(a_if.out), cv_t'(exp));
      end
      a_if.f_ack = 1'b1;
      @(negedge clk);
      a_if.f_ack = 1'b0;
      a_if.in_ready = 1'b0;
      check_val({name, "_ack_rdy"}, cv_t'(a_if.out_ready), cv_t'(0));
      check_val({name, "_ack_bf"},  cv_t'(a_if.buffer_full), cv_t'(final_blk));
   endtask

   // Sends msg_q as full words plus one is_last word, checking block timing and contents.
   task automatic run_msg_a(input string name);
      int len, nwords, nblk, blk, k, p;
      logic is_l;
      logic [31:0] w;
      len = msg_q.size();
      nwords = len / 4 + 1;
      nblk = len / ARB + 1;
      blk = 0;
      for (int wi = 0; wi < nwords; wi++) begin
         is_l = (wi == nwords - 1);
         for (int b = 0; b < 4; b++)
            w[31-8*b -: 8] = (wi*4 + b < len) ? msg_q[wi*4 + b] : 8'($urandom);
         a_if.in = w;
         a_if.is_last = is_l;
         a_if.byte_num = is_l ? 2'(len % 4) : 2'($urandom);
         a_if.in_ready = 1'b1;
         check_val({name, "_bf_idle"}, cv_t'(a_if.buffer_full), cv_t'(0));
         @(negedge clk);
         a_if.in_ready = 1'b0;
         a_if.is_last = 1'b0;
         if (!is_l) begin
            check_val({name, "_rdy_word"}, cv_t'(a_if.out_ready), cv_t'((wi + 1) % ANW == 0));
         end else begin
            k = nwords - (nblk - 1) * ANW;
            p = 0;
            while (!a_if.out_ready && p < ANW + 2) begin
               @(negedge clk);
               p++;
            end
            check_val({name, "_pad_cycles"}, cv_t'(p), cv_t'(ANW - k));
         end
         if (a_if.out_ready) begin
            last_blk = a_if.out;
            check_val($sformatf("%s_blk%0d", name, blk), cv_t'(a_if.out), cv_t'(exp_blk_a(blk)));
            ack_a(name, blk == nblk - 1, exp_blk_a(blk));
            blk++;
         end
      end
      check_val({name, "_nblk"}, cv_t'(blk), cv_t'(nblk));
   endtask

   task automatic run_b(input string name, input int bn, input logic [63:0] w);
      logic [BR-1:0] e;
      int p;
      reset_b(name);
      b_if.in = w;
      b_if.byte_num = 3'(bn);
      b_if.is_last = 1'b1;
      b_if.in_ready = 1'b1;
      @(negedge clk);
      b_if.in_ready = 1'b0;
      b_if.is_last = 1'b0;
      p = 0;
      while (!b_if.out_ready && p < BNWD + 2) begin
         @(negedge clk);
         p++;
      end
      check_val({name, "_pad_cycles"}, cv_t'(p), cv_t'(BNWD - 1));
      e = '0;
      for (int j = 0; j < bn; j++) e[BR-1-8*j -: 8] = w[63-8*j -: 8];
      e[BR-1-8*bn -: 8] = BD;
      e[7:0] = e[7:0] | 8'h80;
      check_val({name, "_blk"}, cv_t'(b_if.out), cv_t'(e));
      b_if.f_ack = 1'b1;
      @(negedge clk);
      b_if.f_ack = 1'b0;
      check_val({name, "_ack_rdy"}, cv_t'(b_if.out_ready), cv_t'(0));
      check_val({name, "_ack_bf"},  cv_t'(b_if.buffer_full), cv_t'(1));
   endtask

   task automatic load_hello();
      string s;
      s = "Hello, world";
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
   endtask

   task automatic load_random(input int len);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
   endtask

   initial begin
      a_if.in = '0; a_if.in_ready = 1'b0; a_if.is_last = 1'b0; a_if.byte_num = '0; a_if.f_ack = 1'b0;
      b_if.in = '0; b_if.in_ready = 1'b0; b_if.is_last = 1'b0; b_if.byte_num = '0; b_if.f_ack = 1'b0;
      repeat (2) @(negedge clk);

      // Short message padded out to a full block.
      reset_a("t1");
      load_hello();
      run_msg_a("t1");
      check_val("t1_text",   cv_t'(last_blk[575:480]), cv_t'(96'h48656c6c6f2c20776f726c64));
      check_val("t1_domain", cv_t'(last_blk[479:472]), cv_t'(8'h01));
      check_val("t1_last",   cv_t'(last_blk[7:0]),     cv_t'(8'h80));

      // DONE: further words are ignored until reset.
      for (int i = 0; i < 10; i++) begin
         a_if.in = $urandom;
         a_if.is_last = 1'($urandom);
         a_if.in_ready = 1'b1;
         @(negedge clk);
         check_val("t6_rdy", cv_t'(a_if.out_ready), cv_t'(0));
         check_val("t6_bf",  cv_t'(a_if.buffer_full), cv_t'(1));
         check_val("t6_out", cv_t'(a_if.out), cv_t'(exp_blk_a(0)));
      end
      a_if.in_ready = 1'b0;

      // Domain byte lands in the last block byte.
      reset_a("t2");
      load_random(71);
      run_msg_a("t2");
      check_val("t2_last", cv_t'(last_blk[7:0]), cv_t'(8'h81));

      // Exactly one block of message forces a second, pad-only block.
      reset_a("t3");
      load_random(72);
      run_msg_a("t3");
      check_val("t3_domain", cv_t'(last_blk[575:568]), cv_t'(8'h01));
      check_val("t3_last",   cv_t'(last_blk[7:0]),     cv_t'(8'h80));

      // Reset in the middle of a block discards it.
      reset_a("t4a");
      for (int i = 0; i < 5; i++) begin
         a_if.in = $urandom;
         a_if.is_last = 1'b0;
         a_if.in_ready = 1'b1;
         @(negedge clk);
      end
      reset_a("t4b");
      load_hello();
      run_msg_a("t4");
      check_val("t4_text", cv_t'(last_blk[575:480]), cv_t'(96'h48656c6c6f2c20776f726c64));

      // Random message lengths across 1..4 blocks.
      for (int n = 0; n < 25; n++) begin
         reset_a($sformatf("r%0d", n));
         load_random($urandom_range(0, 220));
         run_msg_a($sformatf("r%0d", n));
      end

      // 64-bit words, 1088-bit rate, SHA-3 domain.
      run_b("t5", 3, {24'h616263, 40'($urandom)});
      check_val("t5_top",  cv_t'(b_if.out[1087:1056]), cv_t'(32'h61626306));
      check_val("t5_mid",  cv_t'(b_if.out[1055:8]),    cv_t'(0));
      check_val("t5_last", cv_t'(b_if.out[7:0]),       cv_t'(8'h80));
      for (int bn = 0; bn < 8; bn++) begin
         run_b($sformatf("b%0d", bn), bn, {$urandom, $urandom});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
